// File: rtl/multi_dataflow_package.sv
// multi_dataflow_package
//   Shared types for the multi-dataflow engine:
//     CNT_W_DEFAULT          - default width of job-length / output-count fields
//     ctrl_kernel_adapter_t  - control bundle towards the kernel adapter
//     flags_kernel_adapter_t - status flags from the kernel adapter
//     engine_state_t         - engine controller state encoding
package multi_dataflow_package;

  localparam int CNT_W_DEFAULT = 16;

  // Control towards the kernel adapter. Only start is used by the engine
  // controller; cont is reserved for adapters that need an explicit
  // continue handshake and is held low here.
  typedef struct packed {
    logic start;
    logic cont;
  } ctrl_kernel_adapter_t;

  // Status from the kernel adapter.
  typedef struct packed {
    logic done;
    logic ready;
    logic idle;
  } flags_kernel_adapter_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } engine_state_t;

endpackage : multi_dataflow_package

// File: rtl/multi_dataflow_engine_cnt.sv
// multi_dataflow_engine_cnt
//   Saturating up-counter with synchronous clear and count enable.
//   Ports:
//     clk_i  - clock
//     rst_ni - asynchronous active-low reset (count -> 0)
//     clr_i  - synchronous clear, wins over en_i
//     en_i   - increment by one when set; holds at all-ones
//     cnt_o  - current count
module multi_dataflow_engine_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else if (clr_i) begin
      cnt_reg <= '0;
    end else if (en_i && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt_o = cnt_reg;

endmodule : multi_dataflow_engine_cnt

// File: rtl/multi_dataflow_engine_ctrl.sv
// multi_dataflow_engine_ctrl
//   Sequences one kernel job: issues one start pulse per expected kernel
//   output, counts kernel done flags, and signals end of job.
//   Optional watchdog: define MULTI_DATAFLOW_ENGINE_TIMEOUT_EN to abort a
//   COMPUTE phase after TIMEOUT_CYCLES cycles (sets sticky err_o).
//   Ports:
//     clk_i       - clock
//     rst_ni      - asynchronous active-low reset
//     clear_i     - synchronous soft clear, highest priority
//     job_start_i - one-cycle job request, honoured only in IDLE
//     num_out_i   - outputs expected in the job, sampled with job_start_i
//     flags_i     - kernel-adapter flags (only done is used)
//     ctrl_o      - kernel-adapter control (only start driven)
//     busy_o      - job in progress (START/COMPUTE/DONE)
//     job_done_o  - one-cycle end-of-job pulse
//     out_cnt_o   - kernel outputs counted in the current/last job
//     err_o       - sticky watchdog timeout flag (0 without the watchdog)
module multi_dataflow_engine_ctrl
  import multi_dataflow_package::*;
#(
  parameter int CNT_W          = CNT_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  job_start_i,
  input  logic [CNT_W-1:0]      num_out_i,
  input  flags_kernel_adapter_t flags_i,
  output ctrl_kernel_adapter_t  ctrl_o,
  output logic                  busy_o,
  output logic                  job_done_o,
  output logic [CNT_W-1:0]      out_cnt_o,
  output logic                  err_o
);

  engine_state_t    state_reg, state_next;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W:0]   out_cnt_inc;
  logic             len_load;
  logic             cnt_clr;
  logic             cnt_en;
  logic             timeout_hit;

  // ready/idle are informational only; they never steer the FSM.
  logic unused_flags;
  assign unused_flags = flags_i.ready ^ flags_i.idle;

  // One extra bit so that len = 2^CNT_W-1 compares correctly.
  assign out_cnt_inc = {1'b0, out_cnt} + (CNT_W+1)'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_reg <= '0;
    end else if (len_load) begin
      len_reg <= num_out_i;
    end
  end

  always_comb begin
    state_next = state_reg;
    len_load   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    if (clear_i) begin
      state_next = IDLE;
      cnt_clr    = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (job_start_i) begin
            len_load   = 1'b1;
            cnt_clr    = 1'b1;
            state_next = (num_out_i == '0) ? DONE : START;
          end
        end
        START: state_next = COMPUTE;
        COMPUTE: begin
          // A real done wins over a watchdog expiry in the same cycle.
          if (flags_i.done) begin
            cnt_en     = 1'b1;
            state_next = (out_cnt_inc == {1'b0, len_reg}) ? DONE : START;
          end else if (timeout_hit) begin
            state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  multi_dataflow_engine_cnt #(
    .W (CNT_W)
  ) u_out_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (out_cnt)
  );

`ifdef MULTI_DATAFLOW_ENGINE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_clr;
  logic            wd_en;
  logic            err_reg;

  // Watchdog restarts every time COMPUTE is left, so it measures the
  // wait since the most recent start pulse.
  assign wd_clr = clear_i || (state_reg != COMPUTE);
  assign wd_en  = (state_reg == COMPUTE);

  multi_dataflow_engine_cnt #(
    .W (WD_W)
  ) u_wd_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (wd_clr),
    .en_i   (wd_en),
    .cnt_o  (wd_cnt)
  );

  // Counter holds k on the k-th COMPUTE cycle (0-based), so the last
  // permitted cycle is TIMEOUT_CYCLES-1 and DONE follows right after.
  assign timeout_hit = (state_reg == COMPUTE) &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_reg <= 1'b0;
    end else if (clear_i) begin
      err_reg <= 1'b0;
    end else if (timeout_hit && !flags_i.done) begin
      err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  // All job-facing outputs are decoded from the state register.
  always_comb begin
    ctrl_o       = '0;
    ctrl_o.start = (state_reg == START);
  end

  assign busy_o     = (state_reg != IDLE);
  assign job_done_o = (state_reg == DONE);
  assign out_cnt_o  = out_cnt;

endmodule : multi_dataflow_engine_ctrl
